// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle between a UART TX/RX core (master) and the
// fractional baud generator (slave).
interface uart_baud_gen_frac_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OS_W   = 4
);
  logic              en;
  logic              restart;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              tick_os;
  logic              tick_bit;
  logic [OS_W-1:0]   os_phase;
  logic              cfg_pend;

  modport master (
    output en, restart, div_load, div_int, div_frac,
    input  tick_os, tick_bit, os_phase, cfg_pend
  );

  modport slave (
    input  en, restart, div_load, div_int, div_frac,
    output tick_os, tick_bit, os_phase, cfg_pend
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: divides clk by div_int + div_frac/2^FRAC_W,
// producing oversample and bit ticks with double-buffered divisor reload.
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_baud_gen_frac_if.slave bus
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam longint unsigned DEF_Q =
    (64'(CLK_FREQ) << FRAC_W) / (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_Q >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_Q);
  localparam logic [DIV_W-1:0]  DEF_INT_EFF = (DEF_INT < DIV_W'(2)) ? DIV_W'(2) : DEF_INT;
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  last_q, last_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_bit_q, tick_bit_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              boundary_c;
  logic              copy_c;
  logic [FRAC_W:0]   sum_c;

  // Integer divisors below 2 would allow back-to-back ticks.
  function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // acc holds the accumulator after the running period's addition and
  // last holds that period's length minus one, both fixed at period start.
  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    acc_d      = acc_q;
    os_d       = os_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    sum_c      = '0;

    boundary_c = bus.en && (cnt_q == last_q);
    copy_c     = pend_q && (bus.restart || !bus.en || boundary_c);

    if (bus.restart && bus.div_load) begin
      act_int_d  = bus.div_int;
      act_frac_d = bus.div_frac;
      pend_d     = 1'b0;
    end else begin
      if (copy_c) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        pend_d     = 1'b0;
      end
      if (bus.div_load) begin
        sh_int_d  = bus.div_int;
        sh_frac_d = bus.div_frac;
        pend_d    = 1'b1;
      end
    end

    if (bus.restart) begin
      cnt_d  = '0;
      os_d   = '0;
      acc_d  = act_frac_d;
      last_d = clamp_int(act_int_d) - DIV_W'(1);
    end else if (bus.en) begin
      if (boundary_c) begin
        cnt_d      = '0;
        tick_os_d  = 1'b1;
        tick_bit_d = (os_q == OS_LAST);
        os_d       = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
        sum_c      = {1'b0, acc_q} + {1'b0, act_frac_d};
        acc_d      = sum_c[FRAC_W-1:0];
        last_d     = clamp_int(act_int_d) + DIV_W'(sum_c[FRAC_W]) - DIV_W'(1);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      last_q     <= DEF_INT_EFF - DIV_W'(1);
      acc_q      <= DEF_FRAC;
      os_q       <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      act_int_q  <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      sh_int_q   <= DEF_INT;
      sh_frac_q  <= DEF_FRAC;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      os_q       <= os_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.tick_os  = tick_os_q;
  assign bus.tick_bit = tick_bit_q;
  assign bus.os_phase = os_q;
  assign bus.cfg_pend = pend_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: directed timing scenarios plus a randomized
// run compared cycle by cycle against a countdown-based reference model.
module tb_uart_baud_gen_frac;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  uart_baud_gen_frac_if bus ();

  uart_baud_gen_frac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each period is a countdown of remaining enabled edges.
  int   m_int, m_frac, s_int, s_frac, m_acc, m_rem, m_os;
  logic m_pend, e_tos, e_tbit, m_bnd;

  function automatic void m_start();
    int eff;
    eff   = (m_int < 2) ? 2 : m_int;
    m_acc = m_acc + m_frac;
    if (m_acc >= 16) begin
      m_acc = m_acc - 16;
      m_rem = eff + 1;
    end else begin
      m_rem = eff;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_int = 65; m_frac = 1; s_int = 65; s_frac = 1;
        m_pend = 1'b0; m_os = 0; m_acc = 0;
        e_tos = 1'b0; e_tbit = 1'b0;
        m_start();
      end else begin
        e_tos  = 1'b0;
        e_tbit = 1'b0;
        m_bnd  = bus.en && (m_rem == 1);
        if (bus.restart && bus.div_load) begin
          m_int = int'(bus.div_int); m_frac = int'(bus.div_frac); m_pend = 1'b0;
        end else begin
          if (m_pend && (bus.restart || !bus.en || m_bnd)) begin
            m_int = s_int; m_frac = s_frac; m_pend = 1'b0;
          end
          if (bus.div_load) begin
            s_int = int'(bus.div_int); s_frac = int'(bus.div_frac); m_pend = 1'b1;
          end
        end
        if (bus.restart) begin
          m_acc = 0; m_os = 0;
          m_start();
        end else if (bus.en) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            e_tos  = 1'b1;
            e_tbit = (m_os == 15);
            m_os   = (m_os + 1) % 16;
            m_start();
          end
        end
      end
    end
  end

  task automatic load_restart(input int di, input int df);
    @(negedge clk);
    bus.div_int  = 16'(di);
    bus.div_frac = 4'(df);
    bus.div_load = 1'b1;
    bus.restart  = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.restart  = 1'b0;
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.tick_os !== 1'b1 && k < 2000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.restart = 1'b0; bus.div_load = 1'b0;
    bus.div_int = '0; bus.div_frac = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.tick_os !== 1'b0) begin errors++; $display("FAIL reset_tick_os: got %b want 0", bus.tick_os); end
    checks++;
    if (bus.tick_bit !== 1'b0) begin errors++; $display("FAIL reset_tick_bit: got %b want 0", bus.tick_bit); end
    checks++;
    if (bus.os_phase !== 4'd0) begin errors++; $display("FAIL reset_os_phase: got %0d want 0", bus.os_phase); end
    checks++;
    if (bus.cfg_pend !== 1'b0) begin errors++; $display("FAIL reset_cfg_pend: got %b want 0", bus.cfg_pend); end
  endtask

  task automatic test_defaults();
    int k, cyc, ticks, bits, bad;
    bus.en = 1'b1;
    rst_n  = 1'b1;
    wait_tick(k);
    checks++;
    if (k != 65) begin errors++; $display("FAIL default_first_tick: got %0d edges want 65", k); end
    checks++;
    if (bus.os_phase !== 4'd1 || bus.tick_bit !== 1'b0) begin
      errors++; $display("FAIL default_first_phase: phase %0d bit %b want 1 0", bus.os_phase, bus.tick_bit);
    end
    cyc = 0; ticks = 0; bits = 0; bad = 0;
    while (ticks < 16 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.tick_os === 1'b1) ticks++;
      if (bus.tick_bit === 1'b1) begin
        bits++;
        if (bus.tick_os !== 1'b1 || bus.os_phase !== 4'd0) bad++;
      end
    end
    checks++;
    if (cyc != 1041) begin errors++; $display("FAIL default_16_periods: got %0d clk want 1041", cyc); end
    checks++;
    if (bits != 1 || bad != 0) begin errors++; $display("FAIL default_tick_bit: got %0d bits %0d bad want 1 0", bits, bad); end
  endtask

  task automatic test_int4();
    int bad;
    load_restart(4, 0);
    checks++;
    if (bus.cfg_pend !== 1'b0 || bus.os_phase !== 4'd0 || bus.tick_os !== 1'b0) begin
      errors++; $display("FAIL int4_after_restart: pend %b phase %0d tick %b want 0 0 0", bus.cfg_pend, bus.os_phase, bus.tick_os);
    end
    bad = 0;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      if (bus.tick_os !== (i % 4 == 0) || bus.tick_bit !== (i % 64 == 0) ||
          bus.os_phase !== 4'((i / 4) % 16)) begin
        bad++;
        $display("FAIL int4_cycle_%0d: tick %b bit %b phase %0d want %b %b %0d", i, bus.tick_os,
                 bus.tick_bit, bus.os_phase, (i % 4 == 0), (i % 64 == 0), (i / 4) % 16);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_frac();
    int cyc, last, n, bad;
    int len [32];
    load_restart(4, 8);
    cyc = 0; last = 0; n = 0; bad = 0;
    while (n < 32 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.tick_os === 1'b1) begin
        len[n] = cyc - last;
        last = cyc;
        n++;
      end
    end
    checks++;
    if (cyc != 144) begin errors++; $display("FAIL frac_32_periods: got %0d clk want 144", cyc); end
    for (int j = 0; j < n; j++) if (len[j] != ((j % 2 == 1) ? 5 : 4)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frac_alternation: got %0d wrong lengths (first %0d,%0d) want 0", bad, len[0], len[1]); end
  endtask

  task automatic test_midload();
    int k;
    load_restart(4, 0);
    repeat (2) @(negedge clk);
    bus.div_int = 16'd10; bus.div_frac = 4'd0; bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    checks++;
    if (bus.cfg_pend !== 1'b1 || bus.tick_os !== 1'b0) begin
      errors++; $display("FAIL midload_pending: pend %b tick %b want 1 0", bus.cfg_pend, bus.tick_os);
    end
    @(negedge clk);
    checks++;
    if (bus.tick_os !== 1'b1 || bus.cfg_pend !== 1'b0) begin
      errors++; $display("FAIL midload_old_period: tick %b pend %b want 1 0", bus.tick_os, bus.cfg_pend);
    end
    wait_tick(k);
    checks++;
    if (k != 10) begin errors++; $display("FAIL midload_new_period: got %0d want 10", k); end
  endtask

  task automatic test_en_pause();
    int k, bad;
    load_restart(10, 0);
    wait_tick(k);
    checks++;
    if (k != 10) begin errors++; $display("FAIL pause_first_tick: got %0d want 10", k); end
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0 || bus.os_phase !== 4'd1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_frozen: got %0d bad cycles want 0", bad); end
    bus.en = 1'b1;
    wait_tick(k);
    checks++;
    if (k != 7 || bus.os_phase !== 4'd2) begin
      errors++; $display("FAIL pause_resume: got %0d edges phase %0d want 7 2", k, bus.os_phase);
    end
  endtask

  task automatic test_restart_boundary();
    int k, k2;
    load_restart(4, 0);
    wait_tick(k);
    repeat (3) @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    checks++;
    if (bus.tick_os !== 1'b0 || bus.os_phase !== 4'd0) begin
      errors++; $display("FAIL restart_boundary_tick: tick %b phase %0d want 0 0", bus.tick_os, bus.os_phase);
    end
    wait_tick(k);
    checks++;
    if (k != 4 || bus.os_phase !== 4'd1) begin
      errors++; $display("FAIL restart_next_tick: got %0d edges phase %0d want 4 1", k, bus.os_phase);
    end
    for (int v = 0; v < 2; v++) begin
      load_restart(v, 0);
      wait_tick(k);
      wait_tick(k2);
      checks++;
      if (k != 2 || k2 != 2) begin errors++; $display("FAIL clamp_int%0d: got %0d,%0d want 2,2", v, k, k2); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    load_restart(4, 0);
    wait_tick(k);
    bus.div_int = 16'd7; bus.div_frac = 4'd3; bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    checks++;
    if (bus.cfg_pend !== 1'b1) begin errors++; $display("FAIL resetmid_pend_set: got %b want 1", bus.cfg_pend); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cfg_pend !== 1'b0 || bus.os_phase !== 4'd0) begin
      errors++; $display("FAIL resetmid_async: pend %b phase %0d want 0 0", bus.cfg_pend, bus.os_phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(k);
    checks++;
    if (k != 65 || bus.cfg_pend !== 1'b0) begin
      errors++; $display("FAIL resetmid_default: got %0d edges pend %b want 65 0", k, bus.cfg_pend);
    end
  endtask

  task automatic test_random();
    int bad, ticks;
    rst_n = 1'b0;
    bus.en = 1'b1; bus.restart = 1'b0; bus.div_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0; ticks = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.tick_os === 1'b1) ticks++;
      if ({bus.tick_os, bus.tick_bit, bus.os_phase, bus.cfg_pend} !== {e_tos, e_tbit, 4'(m_os), m_pend}) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle_%0d: tick %b bit %b phase %0d pend %b want %b %b %0d %b", i,
                   bus.tick_os, bus.tick_bit, bus.os_phase, bus.cfg_pend, e_tos, e_tbit, m_os, m_pend);
      end
      bus.en       = ($urandom % 8) != 0;
      bus.restart  = ($urandom % 60) == 0;
      bus.div_load = ($urandom % 30) == 0;
      bus.div_int  = 16'($urandom_range(0, 12));
      bus.div_frac = 4'($urandom % 16);
    end
    bus.en = 1'b1; bus.restart = 1'b0; bus.div_load = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_model: got %0d mismatching cycles want 0", bad); end
    checks++;
    if (ticks < 50) begin errors++; $display("FAIL random_activity: got %0d ticks want >= 50", ticks); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_int4();
    test_frac();
    test_midload();
    test_en_pause();
    test_restart_boundary();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
